// File: rtl/writeback_pkg.sv
// writeback_pkg
//   Shared types for the writeback/commit slice: the record handed over by
//   the memory stage, the bypass view of a buffered entry and the registered
//   regfile write port.  WB_DEPTH is the default buffer depth.
package writeback_pkg;

  localparam int WB_DEPTH = 2;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  creg_addr_t;

  typedef struct packed {
    logic regwrite;
    logic hiwrite;
    logic lowrite;
  } ctl_t;

  typedef struct packed {
    word_t pc;
    ctl_t  ctl;
  } instr_t;

  typedef struct packed {
    instr_t     instr;
    creg_addr_t writereg;
    word_t      result;
    word_t      hi;
    word_t      lo;
  } writeback_data_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t addr;
    word_t      data;
  } bypass_t;

  typedef struct packed {
    logic       wen;
    creg_addr_t waddr;
    word_t      wdata;
  } commit_out_t;

  // A record only touches the regfile when it asks to and targets a real
  // register; r0 is hardwired and never written.
  function automatic logic is_rf_write(input writeback_data_t d);
    return d.instr.ctl.regwrite && (d.writereg != '0);
  endfunction

  function automatic bypass_t to_bypass(input logic live, input writeback_data_t d);
    bypass_t b;
    b.valid = live && is_rf_write(d);
    b.addr  = d.writereg;
    b.data  = d.result;
    return b;
  endfunction

endpackage

// File: rtl/writeback_commit_fifo.sv
// wb_fifo
//   Generic DEPTH-entry FIFO of writeback_data_t records.
//   Ports:
//     clk, resetn          clock, synchronous active-low reset
//     push, push_data      enqueue request and record (ignored when full)
//     pop                  dequeue request (ignored when empty)
//     flush                drop every entry; cancels this cycle's push/pop
//     full, empty          occupancy flags from the current count
//     head_data            oldest entry
//     peek_valid/peek_data every slot, oldest at index 0
module wb_fifo
  import writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              push,
  input  writeback_data_t                   push_data,
  input  logic                              pop,
  input  logic                              flush,
  output logic                              full,
  output logic                              empty,
  output writeback_data_t                   head_data,
  output logic            [DEPTH-1:0]       peek_valid,
  output writeback_data_t [DEPTH-1:0]       peek_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  writeback_data_t r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic w_push;
  logic w_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  assign head_data = r_mem[r_head];

  // Pointers are DEPTH-modulo by width since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= push_data;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    peek_valid = '0;
    peek_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      peek_valid[i] = (CW'(i) < r_count);
      peek_data[i]  = r_mem[r_head + PW'(i)];
    end
  end

endmodule

// File: rtl/writeback_commit.sv
// writeback_commit
//   Consumer end of the writeback interface.  Records from the memory stage
//   are buffered in a small FIFO and retired in order: retiring drives the
//   regfile write port, updates architectural HI/LO and bumps the retired
//   instruction counter.  All commit outputs are registered.
//   Optional build macro WB_DEBUG_TRACE_EN adds the debug_wb_* trace ports.
//   Ports:
//     clk, resetn                      clock, synchronous active-low reset
//     in_valid/in_ready/in_data        record handshake from the memory stage
//     flush                            discard buffered, uncommitted records
//     commit_stall                     hold commit this cycle
//     rf_wen/rf_waddr/rf_wdata         regfile write port
//     hi_q, lo_q                       architectural HI/LO
//     byp_valid/byp_addr/byp_data      pending writes, oldest at index 0
//     retired                          retired-instruction count
//     debug_wb_*                       commit trace (WB_DEBUG_TRACE_EN only)
module writeback_commit
  import writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  writeback_data_t             in_data,
  input  logic                        flush,
  input  logic                        commit_stall,
  output logic                        rf_wen,
  output creg_addr_t                  rf_waddr,
  output word_t                       rf_wdata,
  output logic [31:0]                 hi_q,
  output logic [31:0]                 lo_q,
  output logic [DEPTH-1:0]            byp_valid,
  output logic [DEPTH-1:0][4:0]       byp_addr,
  output logic [DEPTH-1:0][31:0]      byp_data,
  output logic [CNT_W-1:0]            retired
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0]                 debug_wb_pc,
  output logic [3:0]                  debug_wb_rf_wen,
  output logic [4:0]                  debug_wb_rf_wnum,
  output logic [31:0]                 debug_wb_rf_wdata
`endif
);

  logic                               w_full;
  logic                               w_empty;
  logic                               w_push;
  logic                               w_commit;
  writeback_data_t                    w_head;
  logic            [DEPTH-1:0]        w_peek_valid;
  writeback_data_t [DEPTH-1:0]        w_peek_data;
  bypass_t         [DEPTH-1:0]        w_byp;

  commit_out_t      r_out;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [CNT_W-1:0] r_retired;

  // in_ready comes from the occupancy alone: a commit in the same cycle
  // never frees a slot for a simultaneous enqueue.
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_commit = !w_empty && !commit_stall && !flush;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (w_push),
    .push_data  (in_data),
    .pop        (w_commit),
    .flush      (flush),
    .full       (w_full),
    .empty      (w_empty),
    .head_data  (w_head),
    .peek_valid (w_peek_valid),
    .peek_data  (w_peek_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_retired <= '0;
    end else begin
      // rf_wen is a one-cycle pulse; address and data hold between writes.
      r_out.wen <= 1'b0;
      if (w_commit) begin
        if (is_rf_write(w_head)) begin
          r_out.wen   <= 1'b1;
          r_out.waddr <= w_head.writereg;
          r_out.wdata <= w_head.result;
        end
        if (w_head.instr.ctl.hiwrite) r_hi <= w_head.hi;
        if (w_head.instr.ctl.lowrite) r_lo <= w_head.lo;
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  assign rf_wen   = r_out.wen;
  assign rf_waddr = r_out.waddr;
  assign rf_wdata = r_out.wdata;
  assign hi_q     = r_hi;
  assign lo_q     = r_lo;
  assign retired  = r_retired;

  always_comb begin
    w_byp     = '0;
    byp_valid = '0;
    byp_addr  = '0;
    byp_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_byp[i]     = to_bypass(w_peek_valid[i], w_peek_data[i]);
      byp_valid[i] = w_byp[i].valid;
      byp_addr[i]  = w_byp[i].addr;
      byp_data[i]  = w_byp[i].data;
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] r_dbg_pc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_dbg_pc <= '0;
    end else if (w_commit) begin
      r_dbg_pc <= w_head.instr.pc;
    end
  end

  assign debug_wb_pc       = r_dbg_pc;
  assign debug_wb_rf_wen   = {4{r_out.wen}};
  assign debug_wb_rf_wnum  = r_out.waddr;
  assign debug_wb_rf_wdata = r_out.wdata;

  logic w_unused_fields;
  assign w_unused_fields = ^w_peek_data;
`else
  // HI/LO/PC of buffered entries are not part of the bypass view, and the
  // head PC is only consumed by the trace port.
  logic w_unused_fields;
  assign w_unused_fields = ^{w_peek_data, w_head.instr.pc};
`endif

endmodule

// File: tb/tb_writeback_commit.sv
module tb_writeback_commit;
  import writeback_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 32;

  logic                   clk;
  logic                   resetn;
  logic                   in_valid;
  logic                   in_ready;
  writeback_data_t        in_data;
  logic                   flush;
  logic                   commit_stall;
  logic                   rf_wen;
  creg_addr_t             rf_waddr;
  word_t                  rf_wdata;
  logic [31:0]            hi_q;
  logic [31:0]            lo_q;
  logic [DEPTH-1:0]       byp_valid;
  logic [DEPTH-1:0][4:0]  byp_addr;
  logic [DEPTH-1:0][31:0] byp_data;
  logic [CNT_W-1:0]       retired;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0]            debug_wb_pc;
  logic [3:0]             debug_wb_rf_wen;
  logic [4:0]             debug_wb_rf_wnum;
  logic [31:0]            debug_wb_rf_wdata;
`endif

  int n_vec = 0;
  int n_bad = 0;

  writeback_commit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .flush        (flush),
    .commit_stall (commit_stall),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .hi_q         (hi_q),
    .lo_q         (lo_q),
    .byp_valid    (byp_valid),
    .byp_addr     (byp_addr),
    .byp_data     (byp_data),
    .retired      (retired)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic writeback_data_t mk(input logic rw, input logic hw, input logic lw,
                                         input logic [4:0] wr, input logic [31:0] res,
                                         input logic [31:0] hi, input logic [31:0] lo,
                                         input logic [31:0] pc);
    writeback_data_t d;
    d.instr.pc           = pc;
    d.instr.ctl.regwrite = rw;
    d.instr.ctl.hiwrite  = hw;
    d.instr.ctl.lowrite  = lw;
    d.writereg           = wr;
    d.result             = res;
    d.hi                 = hi;
    d.lo                 = lo;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn       = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    flush        = 1'b0;
    commit_stall = 1'b0;

    // Reset
    tick();
    tick();
    chk("rst_rf_wen",   64'(rf_wen),    64'd0);
    chk("rst_waddr",    64'(rf_waddr),  64'd0);
    chk("rst_wdata",    64'(rf_wdata),  64'd0);
    chk("rst_hi",       64'(hi_q),      64'd0);
    chk("rst_lo",       64'(lo_q),      64'd0);
    chk("rst_retired",  64'(retired),   64'd0);
    chk("rst_in_ready", 64'(in_ready),  64'd1);
    chk("rst_byp",      64'(byp_valid), 64'd0);
`ifdef WB_DEBUG_TRACE_EN
    chk("rst_dbg_pc",   64'(debug_wb_pc), 64'd0);
`endif

    // Single record r5 <= DEADBEEF
    resetn   = 1'b1;
    in_valid = 1'b1;
    in_data  = mk(1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h1111, 32'h2222, 32'h0000_1000);
    tick();
    in_valid = 1'b0;
    chk("one_wen_early",  64'(rf_wen),      64'd0);
    chk("one_byp_valid",  64'(byp_valid),   64'b01);
    chk("one_byp_addr",   64'(byp_addr[0]), 64'd5);
    chk("one_byp_data",   64'(byp_data[0]), 64'hDEADBEEF);
    tick();
    chk("one_wen",        64'(rf_wen),      64'd1);
    chk("one_waddr",      64'(rf_waddr),    64'd5);
    chk("one_wdata",      64'(rf_wdata),    64'hDEADBEEF);
    chk("one_retired",    64'(retired),     64'd1);
    chk("one_byp_empty",  64'(byp_valid),   64'b00);
    chk("one_hi_kept",    64'(hi_q),        64'd0);
`ifdef WB_DEBUG_TRACE_EN
    chk("one_dbg_pc",     64'(debug_wb_pc), 64'h1000);
    chk("one_dbg_wen",    64'(debug_wb_rf_wen), 64'hF);
`endif
    tick();
    chk("one_wen_pulse",  64'(rf_wen),      64'd0);
    chk("one_waddr_hold", 64'(rf_waddr),    64'd5);

    // r0 write is suppressed but still retires
    in_valid = 1'b1;
    in_data  = mk(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0055, 32'h0, 32'h0, 32'h0000_1004);
    tick();
    in_valid = 1'b0;
    chk("r0_byp",         64'(byp_valid),   64'b00);
    tick();
    chk("r0_wen",         64'(rf_wen),      64'd0);
    chk("r0_waddr_hold",  64'(rf_waddr),    64'd5);
    chk("r0_wdata_hold",  64'(rf_wdata),    64'hDEADBEEF);
    chk("r0_retired",     64'(retired),     64'd2);

    // HI only
    in_valid = 1'b1;
    in_data  = mk(1'b0, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0000_1234, 32'h0000_9999, 32'h0000_1008);
    tick();
    in_valid = 1'b0;
    tick();
    chk("hi_hi",          64'(hi_q),        64'h1234);
    chk("hi_lo",          64'(lo_q),        64'd0);
    chk("hi_wen",         64'(rf_wen),      64'd0);
    chk("hi_retired",     64'(retired),     64'd3);

    // LO only
    in_valid = 1'b1;
    in_data  = mk(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0000_FFFF, 32'h0000_ABCD, 32'h0000_100C);
    tick();
    in_valid = 1'b0;
    tick();
    chk("lo_hi",          64'(hi_q),        64'h1234);
    chk("lo_lo",          64'(lo_q),        64'hABCD);
    chk("lo_retired",     64'(retired),     64'd4);

    // Stall fill: three offered, two accepted
    commit_stall = 1'b1;
    in_valid     = 1'b1;
    in_data      = mk(1'b1, 1'b0, 1'b0, 5'd7, 32'h70, 32'h0, 32'h0, 32'h0000_2000);
    tick();
    chk("fill1_ready",    64'(in_ready),    64'd1);
    in_data      = mk(1'b1, 1'b0, 1'b0, 5'd8, 32'h80, 32'h0, 32'h0, 32'h0000_2004);
    tick();
    chk("fill2_ready",    64'(in_ready),    64'd0);
    chk("fill2_byp",      64'(byp_valid),   64'b11);
    chk("fill2_addr0",    64'(byp_addr[0]), 64'd7);
    chk("fill2_addr1",    64'(byp_addr[1]), 64'd8);
    in_data      = mk(1'b1, 1'b0, 1'b0, 5'd9, 32'h90, 32'h0, 32'h0, 32'h0000_2008);
    tick();
    chk("fill3_ready",    64'(in_ready),    64'd0);
    chk("fill3_addr1",    64'(byp_addr[1]), 64'd8);
    chk("fill3_data1",    64'(byp_data[1]), 64'h80);
    chk("fill3_wen",      64'(rf_wen),      64'd0);
    chk("fill3_retired",  64'(retired),     64'd4);
    in_valid     = 1'b0;
    commit_stall = 1'b0;
    tick();
    chk("drain1_wen",     64'(rf_wen),      64'd1);
    chk("drain1_waddr",   64'(rf_waddr),    64'd7);
    chk("drain1_wdata",   64'(rf_wdata),    64'h70);
    chk("drain1_retired", 64'(retired),     64'd5);
    chk("drain1_ready",   64'(in_ready),    64'd1);
    chk("drain1_byp",     64'(byp_valid),   64'b01);
    chk("drain1_addr0",   64'(byp_addr[0]), 64'd8);
    tick();
    chk("drain2_waddr",   64'(rf_waddr),    64'd8);
    chk("drain2_wdata",   64'(rf_wdata),    64'h80);
    chk("drain2_retired", 64'(retired),     64'd6);
    chk("drain2_byp",     64'(byp_valid),   64'b00);

    // Simultaneous accept and commit while not full
    in_valid = 1'b1;
    in_data  = mk(1'b1, 1'b0, 1'b0, 5'd10, 32'hA0, 32'h0, 32'h0, 32'h0000_3000);
    tick();
    in_data  = mk(1'b1, 1'b0, 1'b0, 5'd11, 32'hB0, 32'h0, 32'h0, 32'h0000_3004);
    tick();
    in_valid = 1'b0;
    chk("both_waddr",     64'(rf_waddr),    64'd10);
    chk("both_byp",       64'(byp_valid),   64'b01);
    chk("both_addr0",     64'(byp_addr[0]), 64'd11);
    chk("both_retired",   64'(retired),     64'd7);
    tick();
    chk("both2_waddr",    64'(rf_waddr),    64'd11);
    chk("both2_wdata",    64'(rf_wdata),    64'hB0);
    chk("both2_retired",  64'(retired),     64'd8);

    // Flush two buffered records; flush wins over stall and cancels enqueue
    commit_stall = 1'b1;
    in_valid     = 1'b1;
    in_data      = mk(1'b1, 1'b1, 1'b0, 5'd12, 32'hC0, 32'h5555, 32'h0, 32'h0000_4000);
    tick();
    in_data      = mk(1'b1, 1'b0, 1'b1, 5'd13, 32'hD0, 32'h0, 32'h6666, 32'h0000_4004);
    tick();
    chk("pre_flush_byp",  64'(byp_valid),   64'b11);
    flush        = 1'b1;
    in_data      = mk(1'b1, 1'b0, 1'b0, 5'd14, 32'hE0, 32'h0, 32'h0, 32'h0000_4008);
    tick();
    flush        = 1'b0;
    in_valid     = 1'b0;
    commit_stall = 1'b0;
    chk("flush_byp",      64'(byp_valid),   64'b00);
    chk("flush_ready",    64'(in_ready),    64'd1);
    chk("flush_wen",      64'(rf_wen),      64'd0);
    chk("flush_retired",  64'(retired),     64'd8);
    chk("flush_hi",       64'(hi_q),        64'h1234);
    chk("flush_lo",       64'(lo_q),        64'hABCD);
    tick();
    chk("post_flush_wen", 64'(rf_wen),      64'd0);
    chk("post_flush_ret", 64'(retired),     64'd8);
    chk("post_flush_adr", 64'(rf_waddr),    64'd11);

    // Reset mid-stream with the buffer full
    commit_stall = 1'b1;
    in_valid     = 1'b1;
    in_data      = mk(1'b1, 1'b1, 1'b1, 5'd20, 32'h1234_5678, 32'hAAAA, 32'hBBBB, 32'h0000_5000);
    tick();
    in_data      = mk(1'b1, 1'b0, 1'b0, 5'd21, 32'h8765_4321, 32'h0, 32'h0, 32'h0000_5004);
    tick();
    in_valid     = 1'b0;
    chk("mid_full",       64'(in_ready),    64'd0);
    resetn       = 1'b0;
    tick();
    chk("mid_rst_wen",    64'(rf_wen),      64'd0);
    chk("mid_rst_waddr",  64'(rf_waddr),    64'd0);
    chk("mid_rst_wdata",  64'(rf_wdata),    64'd0);
    chk("mid_rst_hi",     64'(hi_q),        64'd0);
    chk("mid_rst_lo",     64'(lo_q),        64'd0);
    chk("mid_rst_ret",    64'(retired),     64'd0);
    chk("mid_rst_ready",  64'(in_ready),    64'd1);
    chk("mid_rst_byp",    64'(byp_valid),   64'b00);
    resetn       = 1'b1;
    commit_stall = 1'b0;
    tick();
    tick();
    chk("after_rst_wen",  64'(rf_wen),      64'd0);
    chk("after_rst_ret",  64'(retired),     64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_commit.md
Name: writeback_commit

Overview:
- Consumer end of the writeback interface: accepts writeback_data_t records from the memory stage and retires them.
- Retiring drives the register-file write port, updates architectural HI/LO, and counts retired instructions.
- A 2-entry buffer decouples the memory stage from commit stalls, e.g. a trace sink that is not ready.
- Sits between the memory-stage pipeline register and regfile/hilo; also exports a bypass view of pending writes.

Parameters:
- DEPTH, 2, buffer entries; power of two, 2 or 4.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  memory stage offers a record
- in_ready  out  1  buffer can accept
- in_data  in  writeback_data_t  record (instr, writereg, result, hi, lo)
- flush  in  1  discard all buffered, uncommitted records
- commit_stall  in  1  hold commit this cycle
- rf_wen  out  1  regfile write enable
- rf_waddr  out  creg_addr_t (5)  regfile write address
- rf_wdata  out  word_t (32)  regfile write data
- hi_q  out  32  architectural HI
- lo_q  out  32  architectural LO
- byp_valid  out  DEPTH  per-entry pending-write valid (oldest at index 0)
- byp_addr  out  DEPTH×5  per-entry writereg
- byp_data  out  DEPTH×32  per-entry result
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (resetn=0 at posedge): buffer empty; rf_wen=0, rf_waddr=0, rf_wdata=0; hi_q=lo_q=0; retired=0; in_ready=1; byp_valid=0.
- Accept: record enqueued when in_valid && in_ready at posedge. in_ready = !full, registered-free, computed from the current count only; no same-cycle pass-through credit.
- Commit: head retires at posedge when non-empty && !commit_stall. rf_*, hi_q, lo_q, retired update at that edge. Outputs are registered, so rf_wen pulses the cycle after the head is dequeued. Minimum latency is 2 cycles: accept edge to the edge where rf_wen is visible.
- Regfile write: rf_wen=1 iff instr.ctl.regwrite && writereg != 0; otherwise rf_wen=0 and addr/data hold. Writes to r0 are never issued.
- HI/LO: hi_q <= in.hi if instr.ctl.hiwrite; lo_q <= in.lo if instr.ctl.lowrite; both fields are independent.
- retired increments by 1 per commit; wraps modulo 2^CNT_W.
- Simultaneous accept and commit when full: not allowed. in_ready=0 when full, even if a commit occurs that cycle.
- Simultaneous accept and commit when non-full: both happen; count unchanged.
- flush: at posedge, clears all entries and cancels that cycle's commit and enqueue. rf_wen=0 next cycle. HI/LO and retired are untouched. flush has priority over commit_stall.
- Pointers: DEPTH-modulo head/tail with a count of 0..DEPTH; pointers wrap naturally.
- Bypass: byp_* show buffered, not yet committed entries, oldest first; byp_valid[i] = entry live && regwrite && writereg != 0. Consumers pick the youngest match.
- Reset mid-operation: identical to power-on reset; any in-flight record is lost.

Optional Feature:
- WB_DEBUG_TRACE_EN defined: adds outputs debug_wb_pc (32), debug_wb_rf_wen (4), debug_wb_rf_wnum (5), debug_wb_rf_wdata (32), registered with rf_*.
- debug_wb_rf_wen = {4{rf_wen}}; debug_wb_pc = committed instr.pc; values update only on commit. All are 0 on reset.
- WB_DEBUG_TRACE_EN undefined: the ports and logic are absent; the remaining behaviour is unchanged.

Decomposition:
- writeback_pkg holds WB_DEPTH, the bypass struct typedef (valid, addr, data), and the commit-output struct (wen, waddr, wdata).
- writeback_data_t stays as defined there.
- One sub-module: wb_fifo, a generic DEPTH-entry FIFO of writeback_data_t with flush and an entry-peek vector. The commit/HI/LO/counter logic stays in writeback_commit.

Test Plan:
- Single record: regwrite=1, writereg=5, result=0xDEADBEEF, no stall → rf_wen=1, waddr=5, wdata=0xDEADBEEF two cycles after accept; retired=1.
- r0 write: regwrite=1, writereg=0 → rf_wen stays 0; retired increments.
- HI/LO: hiwrite=1, hi=0x1234, lowrite=0, lo=0x9999 → hi_q=0x1234, lo_q unchanged at 0.
- Stall fill: commit_stall=1 with 3 offered records → in_ready=0 after 2 accepted, byp_valid=2'b11; release stall → commits in order, in_ready=1 again.
- Flush with 2 buffered records → buffer empty next cycle, no rf_wen, retired unchanged, hi_q/lo_q unchanged.
- Reset mid-stream with buffer full → all outputs 0 and in_ready=1 the cycle after resetn=0.
